// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// register_file: 32 x WORD LEGv8 register file, two rising-edge read ports,
// one falling-edge write port, X31 hardwired to zero.      Revision: 1.0
// ============================================================================
module register_file #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      read_register1,
  input  logic [4:0]      read_register2,
  input  logic [4:0]      write_register,
  input  logic [WORD-1:0] write_data,
  input  logic            reg_write,
  output logic [WORD-1:0] read_data1,
  output logic [WORD-1:0] read_data2
);

  localparam logic [4:0] c_XZR = 5'd31;

  logic [WORD-1:0] mem_q [32];
  logic [WORD-1:0] read_data1_q;
  logic [WORD-1:0] read_data2_q;
  logic [WORD-1:0] read_data1_d;
  logic [WORD-1:0] read_data2_d;
  logic            w_write_en;

  function automatic logic [WORD-1:0] reset_image(input int unsigned idx);
    case (idx)
      0:       reset_image = WORD'(256);
      3:       reset_image = WORD'(16);
      5:       reset_image = WORD'(4);
      12:      reset_image = WORD'(17);
      15:      reset_image = WORD'(129);
      19:      reset_image = WORD'(10);
      default: reset_image = '0;
    endcase
  endfunction

  assign w_write_en = reg_write && (write_register != c_XZR);

  // Storage commits on the falling edge so the following rising edge sees it.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= reset_image(i);
      end
    end else if (w_write_en) begin
      mem_q[write_register] <= write_data;
    end
  end

  always_comb begin
    read_data1_d = '0;
    read_data2_d = '0;
    if (read_register1 != c_XZR) read_data1_d = mem_q[read_register1];
    if (read_register2 != c_XZR) read_data2_d = mem_q[read_register2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data1_q <= '0;
      read_data2_q <= '0;
    end else begin
      read_data1_q <= read_data1_d;
      read_data2_q <= read_data2_d;
    end
  end

  assign read_data1 = read_data1_q;
  assign read_data2 = read_data2_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// tb_register_file: scoreboard bench for register_file against an array model.
// Revision: 1.0
// ============================================================================
module tb_register_file;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] d1;
    logic [W-1:0] d2;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [4:0]   read_register1;
  logic [4:0]   read_register2;
  logic [4:0]   write_register;
  logic [W-1:0] write_data;
  logic         reg_write;
  logic [W-1:0] read_data1;
  logic [W-1:0] read_data2;

  logic [W-1:0] model [32];
  exp_t         exp_q [$];
  int           checks = 0;
  int           errors = 0;

  register_file #(.WORD(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [4:0] a);
    return (a == 5'd31) ? '0 : model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model[0] = 256; model[3] = 16; model[5] = 4;
    model[12] = 17; model[15] = 129; model[19] = 10;
  endtask

  // One clock period starting just after a rising edge: inputs are presented,
  // the falling edge may write, the next rising edge produces a read.
  task automatic step(input logic [4:0] ra1, input logic [4:0] ra2, input logic we,
                      input logic [4:0] wa, input logic [W-1:0] wd);
    read_register1 = ra1;
    read_register2 = ra2;
    reg_write      = we;
    write_register = wa;
    write_data     = wd;
    @(negedge clk);
    if (we && wa != 5'd31) model[wa] = wd;
    @(posedge clk);
    exp_q.push_back('{d1: model_read(ra1), d2: model_read(ra2)});
    #1;
  endtask

  // Reset asserted mid-cycle while a write is pending; released between a
  // falling and a rising edge.
  task automatic mid_reset();
    reg_write      = 1'b1;
    write_register = 5'd0;
    write_data     = 64'd999;
    #2;
    reset = 1'b1;
    #1;
    check("reset_clears_rd1", read_data1, '0);
    check("reset_clears_rd2", read_data2, '0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("reset_hold_rd1", read_data1, '0);
    check("reset_hold_rd2", read_data2, '0);
    reg_write      = 1'b0;
    read_register1 = 5'd0;
    read_register2 = 5'd5;
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    exp_q.push_back('{d1: model_read(5'd0), d2: model_read(5'd5)});
    #1;
  endtask

  // Monitor: every rising edge outside reset yields one output pair.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("read_data1", read_data1, e.d1);
        check("read_data2", read_data2, e.d2);
        checks++;
        if ($isunknown({read_data1, read_data2})) begin
          errors++;
          $display("FAIL outputs_known actual=%h_%h required=no X", read_data1, read_data2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]   ra1, ra2, wa;
    logic         we;
    logic [W-1:0] wd;

    reset          = 1'b1;
    read_register1 = 5'd0;
    read_register2 = 5'd5;
    write_register = 5'd0;
    write_data     = '0;
    reg_write      = 1'b0;
    model_reset();
    #1;
    check("init_rd1", read_data1, '0);
    check("init_rd2", read_data2, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    exp_q.push_back('{d1: model_read(5'd0), d2: model_read(5'd5)});
    #1;

    // Directed sequence from the register-file test plan.
    step(5'd3,  5'd19, 1'b0, 5'd0,  '0);
    step(5'd15, 5'd12, 1'b0, 5'd0,  '0);
    step(5'd0,  5'd12, 1'b1, 5'd0,  64'd55);
    step(5'd0,  5'd15, 1'b0, 5'd0,  '0);
    step(5'd0,  5'd15, 1'b1, 5'd15, -64'sd354);
    step(5'd0,  5'd15, 1'b0, 5'd15, 64'd23456);
    step(5'd0,  5'd15, 1'b0, 5'd15, 64'd23456);
    read_register1 = 5'd15;
    #2;
    check("addr_change_hidden", read_data1, 64'd55);
    #(-0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rd1_after_addr_change", read_data1, 64'hFFFF_FFFF_FFFF_FE9E);
    check("rd2_after_addr_change", read_data2, 64'hFFFF_FFFF_FFFF_FE9E);
    step(5'd31, 5'd31, 1'b1, 5'd31, 64'h1234);
    step(5'd31, 5'd0,  1'b0, 5'd31, '0);
    mid_reset();

    // Randomised traffic, biased so reads often hit the written register.
    for (int n = 0; n < 300; n++) begin
      wa  = 5'($urandom_range(0, 31));
      we  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(ra1, ra2, we, wa, wd);
      if (n == 150) mid_reset();
    end

    @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
